// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS boot loader slice.
package mips_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_MAX_CYCLES = 1000;

  localparam logic [31:0] HALT_INST = 32'h0000_000C;
endpackage

// File: rtl/mips_boot_loader_if.sv
// Program-word stream in, instruction-memory write port out.
interface mips_boot_loader_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_cycle_watchdog.sv
// Saturating run-cycle counter with a timeout compare.
module mips_cycle_watchdog #(
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             expire
);
  logic [CYC_W-1:0] count_q;
  logic [CYC_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compared at 32 bits so a budget wider than the counter never fires.
  assign count  = count_q;
  assign expire = en &&
    (32'(count_q) == 32'(MAX_CYCLES - 1));
endmodule

// File: rtl/mips_boot_loader.sv
// Streams a program into instruction memory, then runs the core
// until it fetches the halt word or exhausts its cycle budget.
module mips_boot_loader
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter logic [DATA_W-1:0] HALT_INST =
    DATA_W'(mips_pkg::HALT_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              abort,
  mips_boot_loader_if.slave bus,
  output logic              core_rst,
  input  logic [DATA_W-1:0] core_inst,
  output logic              busy,
  output logic              halted,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [CYC_W-1:0]  cycle_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL =
    (ADDR_W + 1)'(DEPTH);

  state_t          state_q;
  state_t          state_d;
  logic [ADDR_W:0] wc_q;
  logic [ADDR_W:0] wc_d;
  logic            halted_q;
  logic            halted_d;
  logic            timeout_q;
  logic            timeout_d;
  logic            overflow_q;
  logic            overflow_d;

  logic kill;
  logic full;
  logic hs;
  logic wr;
  logic start;
  logic halt_hit;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  // rst is folded in so no write or handshake escapes in its cycle.
  assign kill     = rst || abort;
  assign full     = (wc_q == FULL);
  assign hs       = (state_q == ST_LOAD) && bus.s_valid && !kill;
  assign wr       = hs && !full;
  assign start    = load_start &&
    ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
     (state_q == ST_FAULT));
  assign halt_hit = (state_q == ST_RUN) && (core_inst == HALT_INST);
  assign wd_clr   = abort || start;
  assign wd_en    = (state_q == ST_RUN) && !abort;

  mips_cycle_watchdog #(
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .count  (cycle_count),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (load_start) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (hs && full) begin
            state_d = ST_FAULT;
          end else if (wr && bus.s_last) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_hit) begin
            state_d = ST_DONE;
          end else if (wd_expire) begin
            state_d = ST_FAULT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    core_rst = 1'b1;
    unique case (state_q)
      ST_LOAD: busy = 1'b1;
      ST_RUN: begin
        busy     = 1'b1;
        core_rst = kill;
      end
      default: ;
    endcase
    bus.s_ready    = (state_q == ST_LOAD) && !kill;
    bus.imem_we    = wr;
    bus.imem_addr  = wr ? wc_q[ADDR_W-1:0] : '0;
    bus.imem_wdata = wr ? bus.s_data : '0;
  end

  always_comb begin
    wc_d       = wc_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    if (abort || start) begin
      wc_d       = '0;
      halted_d   = 1'b0;
      timeout_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (wr) wc_d = wc_q + (ADDR_W + 1)'(1);
      if (hs && full) overflow_d = 1'b1;
      if (halt_hit) begin
        halted_d = 1'b1;
      end else if (wd_expire) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wc_q       <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wc_q       <= wc_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  assign word_count = wc_q;
  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench: a wide loader (depth 256, budget 20) and a tiny one
// (depth 4, 3-bit counter) fed from the same stimulus.
module tb_mips_boot_loader;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic [31:0] core_inst = '0;

  always #5 clk = ~clk;

  mips_boot_loader_if #(.DATA_W(32), .ADDR_W(8)) if_a ();
  mips_boot_loader_if #(.DATA_W(32), .ADDR_W(2)) if_b ();

  assign if_a.s_valid = s_valid;
  assign if_a.s_data  = s_data;
  assign if_a.s_last  = s_last;
  assign if_b.s_valid = s_valid;
  assign if_b.s_data  = s_data;
  assign if_b.s_last  = s_last;

  logic        a_crst, a_busy, a_halted, a_timeout, a_overflow;
  logic [8:0]  a_wc;
  logic [15:0] a_cc;
  logic        b_crst, b_busy, b_halted, b_timeout, b_overflow;
  logic [2:0]  b_wc;
  logic [2:0]  b_cc;

  mips_boot_loader #(
    .ADDR_W(8), .CYC_W(16), .MAX_CYCLES(20)
  ) u_dut_a (
    .clk(clk), .rst(rst), .load_start(load_start),
    .abort(abort), .bus(if_a), .core_rst(a_crst),
    .core_inst(core_inst), .busy(a_busy),
    .halted(a_halted), .timeout(a_timeout),
    .overflow(a_overflow), .word_count(a_wc),
    .cycle_count(a_cc)
  );

  mips_boot_loader #(
    .ADDR_W(2), .CYC_W(3), .MAX_CYCLES(20)
  ) u_dut_b (
    .clk(clk), .rst(rst), .load_start(load_start),
    .abort(abort), .bus(if_b), .core_rst(b_crst),
    .core_inst(core_inst), .busy(b_busy),
    .halted(b_halted), .timeout(b_timeout),
    .overflow(b_overflow), .word_count(b_wc),
    .cycle_count(b_cc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  b_writes = 0;

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (if_a.imem_we) begin
      if (exp_q.size() == 0) begin
        chk("a_unexpected_write", 64'(if_a.imem_addr), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("a_wr_addr", 64'(if_a.imem_addr), 64'(mon_e.addr));
        chk("a_wr_data", 64'(if_a.imem_wdata), 64'(mon_e.data));
      end
    end
    if (if_b.imem_we) b_writes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    load_start = 1'b0;
    abort      = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    s_data     = '0;
    core_inst  = '0;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_ready"},    64'(if_a.s_ready),    0);
    chk({t, "_we"},       64'(if_a.imem_we),    0);
    chk({t, "_addr"},     64'(if_a.imem_addr),  0);
    chk({t, "_wdata"},    64'(if_a.imem_wdata), 0);
    chk({t, "_core_rst"}, 64'(a_crst),          1);
    chk({t, "_busy"},     64'(a_busy),          0);
    chk({t, "_halted"},   64'(a_halted),        0);
    chk({t, "_timeout"},  64'(a_timeout),       0);
    chk({t, "_overflow"}, 64'(a_overflow),      0);
    chk({t, "_wc"},       64'(a_wc),            0);
    chk({t, "_cc"},       64'(a_cc),            0);
    chk({t, "_b_crst"},   64'(b_crst),          1);
    chk({t, "_b_ovf"},    64'(b_overflow),      0);
    chk({t, "_b_wc"},     64'(b_wc),            0);
  endtask

  typedef struct {
    logic        ls;
    logic        v;
    logic        last;
    logic [31:0] data;
    logic [31:0] inst;
    logic        ready;
    logic        we;
    logic        crst;
    logic        busy;
    logic [7:0]  addr;
  } vec_t;

  vec_t        tbl[18];
  logic [31:0] prog[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    int b_base;
    logic done;

    prog = '{32'h02309020, 32'h02309022, 32'h02309024,
             32'h02309025, 32'hAE720004, 32'h8E740004};
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b0, 8'h0};
    for (int i = 0; i < 6; i++) begin
      tbl[1+i] = '{1'b0, 1'b1, (i == 5), prog[i], 32'h0,
                   1'b1, 1'b1, 1'b1, 1'b1, 8'(i)};
    end
    for (int i = 0; i < 10; i++) begin
      tbl[7+i] = '{1'b0, 1'b0, 1'b0, 32'h0,
                   (i == 9) ? HALT_INST : 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 8'h0};
    end
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 8'h0};

    // Reset with a live stream word on the bus.
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst0");
    tick();
    idle_in();

    // Six-word program, halt on run cycle 10.
    for (int i = 0; i < 18; i++) begin
      load_start = tbl[i].ls;
      s_valid    = tbl[i].v;
      s_last     = tbl[i].last;
      s_data     = tbl[i].data;
      core_inst  = tbl[i].inst;
      if (tbl[i].we) push(tbl[i].addr, tbl[i].data);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i),
          64'(if_a.s_ready), 64'(tbl[i].ready));
      chk($sformatf("v%0d_we", i),
          64'(if_a.imem_we), 64'(tbl[i].we));
      chk($sformatf("v%0d_core_rst", i),
          64'(a_crst), 64'(tbl[i].crst));
      chk($sformatf("v%0d_busy", i),
          64'(a_busy), 64'(tbl[i].busy));
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("prog_wc",      64'(a_wc),      6);
    chk("prog_halted",  64'(a_halted),  1);
    chk("prog_cc",      64'(a_cc),      10);
    chk("prog_timeout", 64'(a_timeout), 0);
    chk("prog_crst",    64'(a_crst),    1);
    tick();

    // Timeout after exactly 20 run cycles.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("ld_clr_halted", 64'(a_halted), 0);
    chk("ld_clr_cc",     64'(a_cc),     0);
    tick();
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'h1234_5678;
    push(8'h0, s_data);
    tick();
    idle_in();
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (a_crst) done = 1'b1;
      else n++;
      tick();
    end
    chk("to_seen",       64'(done), 1);
    chk("to_run_cycles", 64'(n),    20);
    @(negedge clk);
    chk("to_flag",   64'(a_timeout), 1);
    chk("to_cc",     64'(a_cc),      20);
    chk("to_busy",   64'(a_busy),    0);
    chk("to_halted", 64'(a_halted),  0);
    chk("b_sat_cc",  64'(b_cc),      7);
    chk("b_run",     64'(b_busy),    1);
    repeat (3) tick();
    @(negedge clk);
    chk("fault_hold_to", 64'(a_timeout), 1);
    chk("fault_hold_cc", 64'(a_cc),      20);
    tick();

    // Halt on run cycle 20 beats the timeout.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("ld_clr_to",      64'(a_timeout),    0);
    chk("ld_busy",        64'(a_busy),       1);
    chk("b_ls_ignored",   64'(if_b.s_ready), 0);
    chk("b_ls_busy",      64'(b_busy),       1);
    chk("b_ls_cc",        64'(b_cc),         7);
    tick();
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'hCAFE_0001;
    push(8'h0, s_data);
    tick();
    idle_in();
    for (int k = 1; k <= 20; k++) begin
      core_inst = (k == 20) ? HALT_INST : 32'h0;
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("tie_halted",  64'(a_halted),  1);
    chk("tie_timeout", 64'(a_timeout), 0);
    chk("tie_cc",      64'(a_cc),      20);
    chk("tie_crst",    64'(a_crst),    1);
    chk("b_halted",    64'(b_halted),  1);
    chk("b_halt_cc",   64'(b_cc),      7);
    tick();

    // Overflow on the small loader.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy",   64'(a_busy),   0);
    chk("abort_halted", 64'(a_halted), 0);
    chk("abort_cc",     64'(a_cc),     0);
    chk("abort_wc",     64'(a_wc),     0);
    tick();
    b_base = b_writes;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hB000_0000 + 32'(i);
      push(8'(i), s_data);
      @(negedge clk);
      if (i == 3) chk("b_last_addr", 64'(if_b.imem_addr), 3);
      if (i == 4) chk("b_ovf_no_we", 64'(if_b.imem_we), 0);
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("b_ovf_flag", 64'(b_overflow),        1);
    chk("b_ovf_wc",   64'(b_wc),              4);
    chk("b_ovf_busy", 64'(b_busy),            0);
    chk("b_ovf_crst", 64'(b_crst),            1);
    chk("b_ovf_wr",   64'(b_writes - b_base), 4);
    chk("a_no_ovf",   64'(a_overflow),        0);
    chk("a_wc5",      64'(a_wc),              5);
    tick();

    // Abort on word 3 with s_valid held, then reload from 0.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hA000_0000 + 32'(i);
      push(8'(i), s_data);
      tick();
    end
    s_data = 32'hA000_0002;
    abort  = 1'b1;
    @(negedge clk);
    chk("abort_no_we", 64'(if_a.imem_we), 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle",  64'(a_busy),       0);
    chk("abort_wc0",   64'(a_wc),         0);
    chk("abort_ready", 64'(if_a.s_ready), 0);
    tick();
    s_valid    = 1'b0;
    load_start = 1'b1;
    abort      = 1'b1;
    tick();
    load_start = 1'b0;
    abort      = 1'b0;
    @(negedge clk);
    chk("abort_beats_ls", 64'(a_busy), 0);
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    cnt = 0;
    for (int j = 0; j < 9; j++) begin
      s_valid = (j % 2 == 0);
      s_last  = (j == 8);
      s_data  = 32'h5000_0000 + 32'(j);
      if (s_valid) begin
        push(8'(cnt), s_data);
        cnt++;
      end
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("reload_run", 64'(a_crst), 0);
    chk("reload_wc",  64'(a_wc),   5);
    repeat (3) tick();

    // rst in RUN dominates a same-cycle load_start.
    rst = 1'b1;
    load_start = 1'b1;
    tick();
    rst = 1'b0;
    load_start = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h7777_7777;
    @(negedge clk);
    check_reset("rst1");
    tick();
    idle_in();
    tick();

    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, instruction-memory word-address width; program depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter CYC_W, default 16, width of the run-cycle counter.
REQ-004 Parameter MAX_CYCLES, default 1000, run-cycle budget before timeout.
REQ-005 Parameter HALT_INST, default 32'h0000000C (syscall), fetched word that ends a run.
REQ-006 clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 load_start  input  1  one-cycle pulse that starts a program load; honoured only in IDLE, DONE or FAULT.
REQ-009 abort  input  1  forces an immediate return to IDLE from any state.
REQ-010 s_valid / s_data[DATA_W-1:0] / s_last  inputs  program word stream; s_last marks the final word.
REQ-011 s_ready  output  1  high only in LOAD.
REQ-012 imem_we / imem_addr[ADDR_W-1:0] / imem_wdata[DATA_W-1:0]  outputs  instruction-memory write port.
REQ-013 core_rst  output  1  reset to the MIPS core; high in every state except RUN.
REQ-014 core_inst  input  DATA_W  instruction the core is fetching this cycle.
REQ-015 busy, halted, timeout, overflow  outputs  1 each  status flags.
REQ-016 word_count[ADDR_W:0], cycle_count[CYC_W-1:0]  outputs  words loaded / cycles run.

Function
REQ-017 FSM states are IDLE, LOAD, RUN, DONE and FAULT; busy is high in LOAD and RUN.
REQ-018 IDLE->LOAD on load_start; entering LOAD clears word_count, cycle_count, halted, timeout and overflow.
REQ-019 In LOAD, every cycle with s_valid&&s_ready drives imem_we=1, imem_addr=word_count[ADDR_W-1:0] and imem_wdata=s_data combinationally in that cycle, then increments word_count.
REQ-020 A handshake with s_last=1 moves LOAD->RUN on the next edge; core_rst falls in the first RUN cycle.
REQ-021 If a handshake occurs with word_count==DEPTH and s_last=0, or word_count==DEPTH and s_valid=1 in general, no write occurs, overflow is set and the FSM goes LOAD->FAULT.
REQ-022 A final word written at address DEPTH-1 with s_last=1 is legal and moves to RUN.
REQ-023 In RUN, cycle_count increments every cycle and saturates at 2**CYC_W-1.
REQ-024 In RUN, core_inst==HALT_INST sets halted and moves to DONE on that edge; the cycle_count value includes the halt cycle.
REQ-025 In RUN, cycle_count reaching MAX_CYCLES-1 without a halt sets timeout and moves to FAULT.
REQ-026 If a halt and the timeout occur in the same cycle, halt wins: DONE with halted=1 and timeout=0.
REQ-027 DONE and FAULT hold core_rst=1 and keep all flags and counters until load_start or abort.
REQ-028 abort has priority over every other event, including load_start in the same cycle: next state IDLE, core_rst=1, no imem write that cycle, flags and counters cleared.
REQ-029 load_start during LOAD or RUN is ignored.
REQ-030 imem_we is never high outside LOAD.

Reset
REQ-031 rst puts the FSM in IDLE, sets core_rst=1, and clears s_ready, imem_we, busy, halted, timeout, overflow, word_count and cycle_count; imem_addr and imem_wdata read 0.
REQ-032 rst mid-LOAD or mid-RUN behaves the same as abort; rst dominates abort and load_start.

Structure
REQ-033 A shared package mips_pkg holds the FSM state enum, HALT_INST and the default width constants.
REQ-034 The module has one sub-module, mips_cycle_watchdog: a saturating cycle counter with timeout compare, parameterised by CYC_W and MAX_CYCLES.
REQ-035 Instruction memory is external to this block; its contents are changed only through the imem_* port.

Verification
REQ-036 Load 6 words (02309020, 02309022, 02309024, 02309025, AE720004, 8E740004), with s_last on the 6th word, then core_inst=0000000C at RUN cycle 10 -> imem addresses 0-5 written in order, word_count=6, halted=1, cycle_count=10, core_rst=1.
REQ-037 With ADDR_W=2, stream 5 words with no s_last -> 4 words written, no write on the 5th word, overflow=1, FSM in FAULT.
REQ-038 With MAX_CYCLES=20 and no HALT_INST fetched -> timeout=1 after exactly 20 RUN cycles, core_rst returns to 1.
REQ-039 HALT_INST fetched on RUN cycle MAX_CYCLES -> DONE, halted=1, timeout=0.
REQ-040 abort during load word 3, with s_valid held high -> no imem write that cycle, IDLE, word_count=0; a following load_start reloads from address 0.
REQ-041 s_valid toggled every other cycle during a load, and rst asserted in RUN -> write addresses stay contiguous; after rst every output matches REQ-031.
